// File: rtl/mem_io_responder.sv
// Bus-side responder for the CPU byte-wide memory interface: RAM array plus an
// I/O window (rx/tx byte FIFOs, 32-bit cycle counter with snapshot, program stop).
module mem_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int RX_DEPTH   = 8,
   parameter int TX_DEPTH   = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a,
   input  logic        mem_wr,
   input  logic [7:0]  mem_dout,
   output logic [7:0]  mem_din,
   output logic        rdy_out,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halted
);

   localparam int RXW       = $clog2(RX_DEPTH);
   localparam int TXW       = $clog2(TX_DEPTH);
   localparam int RAM_BYTES = 2 ** ADDR_WIDTH;
   localparam logic [RXW:0] RX_FULL = (RXW + 1)'(RX_DEPTH);
   localparam logic [TXW:0] TX_FULL = (TXW + 1)'(TX_DEPTH);

   logic [7:0] ram    [RAM_BYTES];
   logic [7:0] rx_mem [RX_DEPTH];
   logic [7:0] tx_mem [TX_DEPTH];

   logic [RXW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RXW:0]   rx_count;
   logic [TXW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TXW:0]   tx_count;
   logic [31:0]    cycle_cnt;
   logic [23:0]    snap;

   logic                  io_sel;
   logic [15:0]           io_off;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  unused_addr_bits;

   logic       accept, ram_we, rx_push, rx_pop, tx_push, tx_pop;
   logic       halt_set, snap_load, rx_empty;
   logic [7:0] tx_wdata, rd_byte;

   assign io_sel           = (mem_a[17:16] == 2'b11);
   assign io_off           = mem_a[15:0];
   assign ram_addr         = mem_a[ADDR_WIDTH-1:0];
   assign unused_addr_bits = ^mem_a[31:18];

   // Handshakes: a byte moves on rx when rx_valid && rx_ready and on tx when
   // tx_valid && tx_ready at a clock edge; a bus op takes effect only in a
   // cycle where rdy_out is high, otherwise the CPU holds it unchanged.
   assign accept   = rdy_out;
   assign rdy_out  = !halted && (tx_count != TX_FULL);
   assign rx_ready = (rx_count != RX_FULL);
   assign rx_empty = (rx_count == '0);
   assign tx_valid = (tx_count != '0);
   assign tx_data  = tx_mem[tx_rd_ptr];

   always_comb begin
      ram_we    = accept && mem_wr && !io_sel;
      rx_push   = rx_valid && rx_ready;
      rx_pop    = accept && !mem_wr && io_sel && (io_off == 16'h0000) && !rx_empty;
      tx_pop    = tx_valid && tx_ready;
      snap_load = accept && !mem_wr && io_sel && (io_off == 16'h0004);
      halt_set  = accept && mem_wr && io_sel && (io_off == 16'h0004);
      tx_push   = 1'b0;
      tx_wdata  = mem_dout;
      if (accept && mem_wr && io_sel) begin
         if ((io_off == 16'h0000) && (mem_dout != 8'h00)) begin
            tx_push = 1'b1;
         end else if (io_off == 16'h0004) begin
            tx_push  = 1'b1;
            tx_wdata = 8'h00;
         end
      end
   end

   // Read data is a pure function of the address so it can update every cycle.
   always_comb begin
      rd_byte = 8'h00;
      if (!io_sel) begin
         rd_byte = ram[ram_addr];
      end else begin
         case (io_off)
            16'h0000: rd_byte = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
            16'h0004: rd_byte = cycle_cnt[7:0];
            16'h0005: rd_byte = snap[7:0];
            16'h0006: rd_byte = snap[15:8];
            16'h0007: rd_byte = snap[23:16];
            default:  rd_byte = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (ram_we)  ram[ram_addr]       <= mem_dout;
      if (rx_push) rx_mem[rx_wr_ptr]   <= rx_data;
      if (tx_push) tx_mem[tx_wr_ptr]   <= tx_wdata;
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mem_din   <= 8'h00;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         cycle_cnt <= 32'h0;
         snap      <= 24'h0;
         halted    <= 1'b0;
      end else begin
         mem_din <= rd_byte;
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: rx_count <= rx_count;
         endcase
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: tx_count <= tx_count;
         endcase
         if (!halted)   cycle_cnt <= cycle_cnt + 32'd1;
         if (snap_load) snap      <= cycle_cnt[31:8];
         if (halt_set)  halted    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: queue/array model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_mem_io_responder;

   localparam int ADDR_WIDTH = 17;
   localparam int RX_DEPTH   = 8;
   localparam int TX_DEPTH   = 8;

   logic        clk_in   = 1'b0;
   logic        rst_in   = 1'b1;
   logic [31:0] mem_a    = 32'h0;
   logic        mem_wr   = 1'b0;
   logic [7:0]  mem_dout = 8'h00;
   logic [7:0]  mem_din;
   logic        rdy_out;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        halted;

   mem_io_responder #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .RX_DEPTH(RX_DEPTH),
      .TX_DEPTH(TX_DEPTH)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .mem_a(mem_a),
      .mem_wr(mem_wr),
      .mem_dout(mem_dout),
      .mem_din(mem_din),
      .rdy_out(rdy_out),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .halted(halted)
   );

   always #5 clk_in = ~clk_in;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0]  m_ram [int];
   logic [7:0]  m_rx_q [$];
   logic [7:0]  m_tx_q [$];
   logic [7:0]  dut_tx_log [$];
   logic [31:0] m_cnt;
   logic [31:0] m_snap;
   logic        m_halted;
   logic [7:0]  m_din;
   bit          m_din_chk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic model_reset();
      m_rx_q.delete();
      m_tx_q.delete();
      m_cnt     = 32'h0;
      m_snap    = 32'h0;
      m_halted  = 1'b0;
      m_din     = 8'h00;
      m_din_chk = 1'b1;
   endtask

   function automatic bit m_rdy();
      return !m_halted && (m_tx_q.size() != TX_DEPTH);
   endfunction

   // One clock edge of the responder's observable behaviour, from the inputs
   // present just before the edge.
   task automatic model_step();
      bit          acc, is_io, rx_push, tx_pop;
      logic [15:0] off;
      int          ra;
      logic [7:0]  din_n;
      acc     = m_rdy();
      is_io   = (mem_a[17:16] == 2'b11);
      off     = mem_a[15:0];
      ra      = int'(mem_a[ADDR_WIDTH-1:0]);
      rx_push = rx_valid && (m_rx_q.size() < RX_DEPTH);
      tx_pop  = tx_ready && (m_tx_q.size() > 0);
      din_n   = 8'h00;
      m_din_chk = !mem_wr;
      if (!is_io) begin
         if (m_ram.exists(ra)) din_n = m_ram[ra];
         else m_din_chk = 1'b0;
      end else if (off == 16'h0000) begin
         if (m_rx_q.size() > 0) din_n = m_rx_q[0];
      end else if (off == 16'h0004) begin
         din_n = m_cnt[7:0];
      end else if (off >= 16'h0005 && off <= 16'h0007) begin
         din_n = 8'(m_snap >> (8 * (off - 16'h0004)));
      end
      if (tx_pop) void'(m_tx_q.pop_front());
      if (acc) begin
         if (mem_wr) begin
            if (!is_io) m_ram[ra] = mem_dout;
            else if (off == 16'h0000 && mem_dout != 8'h00) m_tx_q.push_back(mem_dout);
            else if (off == 16'h0004) m_tx_q.push_back(8'h00);
         end else if (is_io) begin
            if (off == 16'h0000 && m_rx_q.size() > 0) void'(m_rx_q.pop_front());
            else if (off == 16'h0004) m_snap = m_cnt;
         end
      end
      if (rx_push) m_rx_q.push_back(rx_data);
      if (!m_halted) m_cnt = m_cnt + 32'd1;
      if (acc && mem_wr && is_io && off == 16'h0004) m_halted = 1'b1;
      m_din = din_n;
   endtask

   always @(posedge clk_in) begin
      if (rst_in) begin
         if (tx_valid && tx_ready) dut_tx_log.push_back(tx_data);
         model_step();
      end
      #1;
      check("rdy_out", 32'(rdy_out), 32'(m_rdy()));
      check("halted", 32'(halted), 32'(m_halted));
      check("tx_valid", 32'(tx_valid), 32'(m_tx_q.size() != 0));
      check("rx_ready", 32'(rx_ready), 32'(m_rx_q.size() != RX_DEPTH));
      if (m_tx_q.size() != 0) check("tx_data", 32'(tx_data), 32'(m_tx_q[0]));
      if (m_din_chk) check("mem_din", 32'(mem_din), 32'(m_din));
   end

   task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
      bit ok;
      ok = 1'b0;
      @(negedge clk_in);
      mem_a = a; mem_wr = wr; mem_dout = d;
      for (int i = 0; i < 64 && !ok; i++) begin
         ok = rdy_out;
         @(posedge clk_in);
         if (!ok) @(negedge clk_in);
      end
      if (!ok) check("bus_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      @(negedge clk_in);
      mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_mem_din"}, 32'(mem_din), 32'h00);
      check({tag, "_rdy_out"}, 32'(rdy_out), 32'd1);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
      check({tag, "_halted"}, 32'(halted), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst_in = 1'b0;
      model_reset();
      #1;
      reset_checks(tag);
      repeat (2) @(negedge clk_in);
      mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00; rx_valid = 1'b0;
      rst_in = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      do_reset("por");

      // RAM round trip, aliasing and unmapped IO
      bus(32'h0000_0010, 1'b1, 8'hA5);
      bus(32'h0000_0010, 1'b0, 8'h00);
      #1 check("ram_rt", 32'(mem_din), 32'hA5);
      bus(32'h0002_0010, 1'b1, 8'h5C);
      bus(32'h0000_0010, 1'b0, 8'h00);
      #1 check("ram_alias", 32'(mem_din), 32'h5C);
      bus(32'h0003_0008, 1'b0, 8'h00);
      #1 check("io_unmapped", 32'(mem_din), 32'h00);

      // Output path: 0x00 and writes to other IO offsets are dropped
      tx_ready = 1'b1;
      dut_tx_log.delete();
      bus(32'h0003_0000, 1'b1, 8'h48);
      bus(32'h0003_0000, 1'b1, 8'h00);
      bus(32'h0003_0001, 1'b1, 8'h77);
      bus(32'h0003_0000, 1'b1, 8'h49);
      idle(4);
      check("tx_count", 32'(dut_tx_log.size()), 32'd2);
      if (dut_tx_log.size() == 2) begin
         check("tx_byte0", 32'(dut_tx_log[0]), 32'h48);
         check("tx_byte1", 32'(dut_tx_log[1]), 32'h49);
      end

      // Backpressure
      tx_ready = 1'b0;
      dut_tx_log.delete();
      for (int i = 0; i < TX_DEPTH; i++) begin
         bus(32'h0003_0000, 1'b1, 8'(8'h60 + i));
         #1 check("bp_rdy", 32'(rdy_out), (i < TX_DEPTH - 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk_in);
      mem_a = 32'h0003_0000; mem_wr = 1'b1; mem_dout = 8'h5A;
      repeat (2) @(negedge clk_in);
      check("bp_stalled", 32'(rdy_out), 32'd0);
      tx_ready = 1'b1;
      @(negedge clk_in);
      tx_ready = 1'b0;
      check("bp_reopen", 32'(rdy_out), 32'd1);
      @(negedge clk_in);
      mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
      check("bp_refull", 32'(rdy_out), 32'd0);
      tx_ready = 1'b1;
      repeat (12) @(negedge clk_in);
      check("bp_drained", 32'(tx_valid), 32'd0);
      check("bp_log_size", 32'(dut_tx_log.size()), 32'd9);
      if (dut_tx_log.size() == 9) begin
         check("bp_first", 32'(dut_tx_log[0]), 32'h60);
         check("bp_eighth", 32'(dut_tx_log[7]), 32'h67);
         check("bp_held", 32'(dut_tx_log[8]), 32'h5A);
      end

      // Input path
      @(negedge clk_in); rx_data = 8'h31; rx_valid = 1'b1;
      @(negedge clk_in); rx_data = 8'h32;
      @(negedge clk_in); rx_valid = 1'b0;
      bus(32'h0003_0000, 1'b0, 8'h00);
      #1 check("rx_first", 32'(mem_din), 32'h31);
      bus(32'h0003_0000, 1'b0, 8'h00);
      #1 check("rx_second", 32'(mem_din), 32'h32);
      bus(32'h0003_0000, 1'b0, 8'h00);
      #1 check("rx_empty", 32'(mem_din), 32'h00);
      idle(1);
      check("rx_ready_kept", 32'(rx_ready), 32'd1);

      // rx overflow: ninth byte offered to a full FIFO is not taken
      for (int i = 0; i <= RX_DEPTH; i++) begin
         @(negedge clk_in); rx_data = 8'(8'h80 + i); rx_valid = 1'b1;
      end
      @(negedge clk_in); rx_valid = 1'b0;
      check("rx_full", 32'(rx_ready), 32'd0);
      for (int i = 0; i < RX_DEPTH; i++) begin
         bus(32'h0003_0000, 1'b0, 8'h00);
         #1 check("rx_drain", 32'(mem_din), 32'(8'h80 + i));
      end
      bus(32'h0003_0000, 1'b0, 8'h00);
      #1 check("rx_drain_empty", 32'(mem_din), 32'h00);
      idle(1);

      // Counter coherence across the 0xFF -> 0x100 carry
      @(negedge clk_in); #2;
      do_reset("cnt");
      for (int i = 0; i < 600 && m_cnt != 32'hFE; i++) @(negedge clk_in);
      if (m_cnt != 32'hFE) check("cnt_wait_timeout", m_cnt, 32'hFE);
      bus(32'h0003_0004, 1'b0, 8'h00);
      #1 check("cnt_b0", 32'(mem_din), 32'hFF);
      bus(32'h0003_0005, 1'b0, 8'h00);
      #1 check("cnt_b1", 32'(mem_din), 32'h00);
      bus(32'h0003_0006, 1'b0, 8'h00);
      #1 check("cnt_b2", 32'(mem_din), 32'h00);
      bus(32'h0003_0007, 1'b0, 8'h00);
      #1 check("cnt_b3", 32'(mem_din), 32'h00);
      bus(32'h0003_0005, 1'b0, 8'h00);
      #1 check("cnt_snap_held", 32'(mem_din), 32'h00);
      bus(32'h0003_0004, 1'b0, 8'h00);
      #1 check("cnt_live", 32'(mem_din), 32'h04);
      bus(32'h0003_0005, 1'b0, 8'h00);
      #1 check("cnt_snap_new", 32'(mem_din), 32'h01);

      // Halt: emits 0x00, counter frozen at 0x107
      tx_ready = 1'b1;
      dut_tx_log.delete();
      bus(32'h0003_0004, 1'b1, 8'h00);
      #1;
      check("halt_flag", 32'(halted), 32'd1);
      check("halt_rdy", 32'(rdy_out), 32'd0);
      @(negedge clk_in);
      mem_a = 32'h0003_0004; mem_wr = 1'b0;
      repeat (4) @(posedge clk_in);
      #1 check("halt_frozen", 32'(mem_din), 32'h07);
      idle(2);
      check("halt_log_size", 32'(dut_tx_log.size()), 32'd1);
      if (dut_tx_log.size() == 1) check("halt_log_byte", 32'(dut_tx_log[0]), 32'h00);

      // Reset in the middle of a post-halt drain
      @(negedge clk_in); #2;
      do_reset("rst2");
      tx_ready = 1'b0;
      dut_tx_log.delete();
      bus(32'h0003_0000, 1'b1, 8'h41);
      bus(32'h0003_0000, 1'b1, 8'h42);
      bus(32'h0003_0004, 1'b1, 8'h00);
      @(negedge clk_in);
      mem_a = 32'h0000_0010; mem_wr = 1'b0;
      check("h2_halted", 32'(halted), 32'd1);
      check("h2_rdy", 32'(rdy_out), 32'd0);
      check("h2_head", 32'(tx_data), 32'h41);
      @(posedge clk_in);
      #1 check("h2_ram_read", 32'(mem_din), 32'h5C);
      tx_ready = 1'b1;
      @(posedge clk_in);
      #2;
      check("h2_middrain_valid", 32'(tx_valid), 32'd1);
      check("h2_middrain_head", 32'(tx_data), 32'h42);
      do_reset("middrain");
      check("h2_log_size", 32'(dut_tx_log.size()), 32'd1);
      if (dut_tx_log.size() == 1) check("h2_log_byte", 32'(dut_tx_log[0]), 32'h41);
      idle(3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
